// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
//   Accepts symbolic LEGv8 instruction requests over a valid/ready handshake,
//   encodes each into its 32-bit R, D, I or CB word and writes legal words to
//   consecutive instruction-memory addresses through a registered write port.
//
// Ports
//   clk, reset (active-low async)  clock and reset
//   start                          pulse: begin a new load at address 0
//   req_valid / req_ready          request handshake
//   req_op, req_rd, req_rn,        symbolic instruction fields
//   req_rm, req_imm, req_last
//   mem_we, mem_addr, mem_wdata    instruction-memory write port (1-cycle latency)
//   count                          legal words accepted since start
//   done                           load finished
//   err                            sticky illegal-op / immediate-range flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | accepting requests, writing legal words
// DONE  | last instruction seen or memory full; waiting for next start

module legv8_instr_encoder #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rn,
    input  logic [4:0]    req_rm,
    input  logic [18:0]   req_imm,
    input  logic          req_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          enc_legal;
    logic [31:0]   enc_word;
    logic          d_imm_ok;
    logic          i_imm_ok;

    // D-type offset -256..255: upper bits are a pure sign extension of bit 8.
    assign d_imm_ok = (&req_imm[18:8]) | ~(|req_imm[18:8]);
    // I-type immediate 0..4095: everything above bit 11 (sign included) is zero.
    assign i_imm_ok = ~(|req_imm[18:12]);

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (req_op)
            4'd0:  enc_word = {11'b10001011000, req_rm, 6'b000000, req_rn, req_rd};
            4'd1:  enc_word = {11'b11001011000, req_rm, 6'b000000, req_rn, req_rd};
            4'd2:  enc_word = {11'b10001010000, req_rm, 6'b000000, req_rn, req_rd};
            4'd3:  enc_word = {11'b10101010000, req_rm, 6'b000000, req_rn, req_rd};
            4'd4:  enc_word = {11'b10101011000, req_rm, 6'b000000, req_rn, req_rd};
            4'd5:  enc_word = {11'b11101011000, req_rm, 6'b000000, req_rn, req_rd};
            4'd6: begin
                enc_word  = {11'b11111000010, req_imm[8:0], 2'b00, req_rn, req_rd};
                enc_legal = d_imm_ok;
            end
            4'd7: begin
                enc_word  = {11'b11111000000, req_imm[8:0], 2'b00, req_rn, req_rd};
                enc_legal = d_imm_ok;
            end
            4'd8:  enc_word = {8'b10110100, req_imm, req_rd};
            4'd9: begin
                enc_word  = {10'b1001000100, req_imm[11:0], req_rn, req_rd};
                enc_legal = i_imm_ok;
            end
            4'd10: begin
                enc_word  = {10'b1101000100, req_imm[11:0], req_rn, req_rd};
                enc_legal = i_imm_ok;
            end
            4'd11: begin
                enc_word  = {10'b1011000100, req_imm[11:0], req_rn, req_rd};
                enc_legal = i_imm_ok;
            end
            4'd12: begin
                enc_word  = {10'b1111000100, req_imm[11:0], req_rn, req_rd};
                enc_legal = i_imm_ok;
            end
            // B.cond: Rt field carries the 4-bit condition, bit 4 forced to 0.
            4'd13: enc_word = {8'b01010100, req_imm, 1'b0, req_rd[3:0]};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A write registered on the final transfer is already on the
                // port this cycle, so a start here does not disturb it.
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (req_valid) begin
                    if (enc_legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[AW-1:0];
                        mem_wdata_d = enc_word;
                        count_d     = count_q + ONE_CNT;
                    end else begin
                        err_d = 1'b1;
                    end
                    // Stop on the word that fills memory so the address never wraps.
                    if (req_last || (enc_legal && (count_q == LAST_CNT))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);
    assign count     = count_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Testbench for legv8_instr_encoder: scenario tasks drive requests and push
// expected writes into a scoreboard queue; a negedge monitor pops and
// compares every write the DUT issues.

module tb_legv8_instr_encoder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          reset;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rn;
    logic [4:0]    req_rm;
    logic [18:0]   req_imm;
    logic          req_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err;

    legv8_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_imm   (req_imm),
        .req_last  (req_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   exp_addr;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference encoder built from numeric opcodes and shifts.
    function automatic logic [32:0] model_enc(input int op, input int rd, input int rn,
                                              input int rm, input int imm);
        logic [31:0] w;
        logic        ok;
        int          opc;
        w   = 32'd0;
        ok  = 1'b1;
        opc = 0;
        if (op >= 0 && op <= 5) begin
            case (op)
                0: opc = 'h458;
                1: opc = 'h658;
                2: opc = 'h450;
                3: opc = 'h550;
                4: opc = 'h558;
                default: opc = 'h758;
            endcase
            w = (32'(opc) << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd);
        end else if (op == 6 || op == 7) begin
            opc = (op == 6) ? 'h7C2 : 'h7C0;
            ok  = (imm >= -256) && (imm <= 255);
            w   = (32'(opc) << 21) | (32'(imm & 'h1FF) << 12) | (32'(rn) << 5) | 32'(rd);
        end else if (op >= 9 && op <= 12) begin
            case (op)
                9:  opc = 'h244;
                10: opc = 'h344;
                11: opc = 'h2C4;
                default: opc = 'h3C4;
            endcase
            ok = (imm >= 0) && (imm <= 4095);
            w  = (32'(opc) << 22) | (32'(imm & 'hFFF) << 10) | (32'(rn) << 5) | 32'(rd);
        end else if (op == 8) begin
            w = (32'h0B4 << 24) | (32'(imm & 'h7FFFF) << 5) | 32'(rd);
        end else if (op == 13) begin
            w = (32'h054 << 24) | (32'(imm & 'h7FFFF) << 5) | 32'(rd & 'hF);
        end else begin
            ok = 1'b0;
        end
        return {ok, w};
    endfunction

    // Drives one request (expected to be accepted) and records its write.
    task automatic drive(input int op, input int rd, input int rn, input int rm,
                         input int imm, input bit last);
        logic [32:0] r;
        exp_t        e;
        req_valid = 1'b1;
        req_op    = 4'(op);
        req_rd    = 5'(rd);
        req_rn    = 5'(rn);
        req_rm    = 5'(rm);
        req_imm   = 19'(imm);
        req_last  = last;
        r = model_enc(op, rd, rn, rm, imm);
        if (r[32]) begin
            e.addr = exp_addr;
            e.data = r[31:0];
            exp_q.push_back(e);
            exp_addr++;
        end
    endtask

    task automatic do_start();
        req_valid = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected addr=%0d data=%h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== 6'(e.addr) || mem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL wr_data got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b expected 0", req_ready); end
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got %b expected 0", mem_we); end
        total++;
        if (mem_addr !== '0) begin bad++; $display("FAIL rst_addr got %0d expected 0", mem_addr); end
        total++;
        if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got %h expected 0", mem_wdata); end
        total++;
        if (count !== '0) begin bad++; $display("FAIL rst_count got %0d expected 0", count); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b expected 0", done); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err got %b expected 0", err); end
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got %0d writes outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_add();
        do_start();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL add_ready got %b expected 1", req_ready); end
        drive(0, 1, 2, 3, 0, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'h8B030041) begin
            bad++;
            $display("FAIL add_word got we=%b addr=%0d data=%h expected we=1 addr=0 data=8b030041",
                     mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (count !== 7'd1 || done !== 1'b1) begin
            bad++; $display("FAIL add_count got count=%0d done=%b expected 1/1", count, done);
        end
        check_drained("add");
    endtask

    task automatic test_back_to_back();
        do_start();
        drive(6, 9, 10, 0, 8, 1'b0);
        tick();
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'hF8408149) begin
            bad++;
            $display("FAIL b2b_ldur got we=%b addr=%0d data=%h expected we=1 addr=0 data=f8408149",
                     mem_we, mem_addr, mem_wdata);
        end
        drive(9, 5, 5, 0, 1, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_wdata !== 32'h910004A5) begin
            bad++;
            $display("FAIL b2b_addi got we=%b addr=%0d data=%h expected we=1 addr=1 data=910004a5",
                     mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (err !== 1'b0 || count !== 7'd2) begin
            bad++; $display("FAIL b2b_status got err=%b count=%0d expected 0/2", err, count);
        end
        check_drained("b2b");
    endtask

    task automatic test_branch_and_restart();
        do_start();
        drive(8, 7, 0, 0, -2, 1'b0);
        tick();
        total++;
        if (mem_wdata !== 32'hB4FFFFC7 || mem_addr !== 6'd0) begin
            bad++; $display("FAIL cbz_word got addr=%0d data=%h expected 0/b4ffffc7", mem_addr, mem_wdata);
        end
        drive(13, 0, 0, 0, 3, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_wdata !== 32'h54000060 || mem_addr !== 6'd1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL bcond_word got we=%b addr=%0d data=%h expected 1/1/54000060",
                            mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (done !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL bcond_done got done=%b ready=%b expected 1/0", done, req_ready);
        end
        // start in the first DONE cycle, while the final write is on the port
        do_start();
        total++;
        if (req_ready !== 1'b1 || count !== '0 || done !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL restart got ready=%b count=%0d done=%b we=%b expected 1/0/0/0",
                            req_ready, count, done, mem_we);
        end
        drive(13, 5'h1E, 0, 0, -1, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_addr !== 6'd0 || count !== 7'd1) begin
            bad++; $display("FAIL restart_addr got addr=%0d count=%0d expected 0/1", mem_addr, count);
        end
        check_drained("branch");
    endtask

    task automatic test_illegal();
        do_start();
        drive(7, 1, 2, 0, 300, 1'b0);
        tick();
        total++;
        if (mem_we !== 1'b0 || count !== '0 || err !== 1'b1) begin
            bad++; $display("FAIL ill_imm got we=%b count=%0d err=%b expected 0/0/1", mem_we, count, err);
        end
        drive(14, 1, 2, 3, 0, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_we !== 1'b0 || count !== '0 || err !== 1'b1 || done !== 1'b1) begin
            bad++; $display("FAIL ill_op got we=%b count=%0d err=%b done=%b expected 0/0/1/1",
                            mem_we, count, err, done);
        end
        do_start();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL ill_clear got err=%b expected 0", err); end
        // range edges: -256 and 4095 legal, 4096 illegal
        drive(6, 3, 4, 0, -256, 1'b0);
        tick();
        drive(12, 3, 4, 0, 4095, 1'b0);
        tick();
        drive(10, 3, 4, 0, 4096, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (count !== 7'd2 || err !== 1'b1 || done !== 1'b1) begin
            bad++; $display("FAIL ill_edges got count=%0d err=%b done=%b expected 2/1/1", count, err, done);
        end
        check_drained("illegal");
    endtask

    task automatic test_full();
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            drive($urandom_range(0, 5), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), 0, 1'b0);
            tick();
            total++;
            if (count !== 7'(i + 1)) begin
                bad++; $display("FAIL full_count got %0d expected %0d", count, i + 1);
            end
        end
        total++;
        if (done !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL full_done got done=%b ready=%b expected 1/0", done, req_ready);
        end
        // keep offering a 65th request; it must not be taken
        tick();
        tick();
        req_valid = 1'b0;
        total++;
        if (count !== 7'd64 || req_ready !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL full_hold got count=%0d ready=%b we=%b expected 64/0/0",
                            count, req_ready, mem_we);
        end
        check_drained("full");
    endtask

    task automatic test_reset_mid_load();
        do_start();
        for (int i = 0; i < 10; i++) begin
            drive(1, i, i + 1, i + 2, 0, 1'b0);
            tick();
        end
        reset = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        do_start();
        drive(3, 4, 5, 6, 0, 1'b1);
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || count !== 7'd1) begin
            bad++; $display("FAIL rst_mid_next got we=%b addr=%0d count=%0d expected 1/0/1",
                            mem_we, mem_addr, count);
        end
        check_drained("rst_mid");
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_addr  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_rd    = '0;
        req_rn    = '0;
        req_rm    = '0;
        req_imm   = '0;
        req_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        test_reset();
        test_add();
        test_back_to_back();
        test_branch_and_restart();
        test_illegal();
        test_full();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
